// File: rtl/bram_bank_ring_pkg.sv
// Shared types and helpers for the BRAM bank ring: bank states, overflow
// counter width and a constant-evaluable clog2.
package bram_bank_ring_pkg;

  typedef enum logic [1:0] {
    FREE,
    FILL,
    FULL
  } bank_state_e;

  localparam int OVF_CNT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bram_bank_ptr.sv
// Wrapping bank pointer: advances by one on i_inc, wraps NUM_BANKS-1 -> 0.
module bram_bank_ptr
  import bram_bank_ring_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = clog2(NUM_BANKS)
) (
  input  logic              trn_clk,
  input  logic              trn_reset,
  input  logic              i_inc,
  output logic [BANK_W-1:0] o_ptr
);

  localparam logic [BANK_W-1:0] LAST = BANK_W'(NUM_BANKS - 1);

  logic [BANK_W-1:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset)  r_ptr <= '0;
    else if (i_inc) r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/bram_bank_ring.sv
// Ring of NUM_BANKS BRAM banks: a writer fills banks in order, a reader drains
// full banks oldest-first. Optional macro DDRBRAM_OVF_COUNT_EN adds ovf_cnt.
module bram_bank_ring
  import bram_bank_ring_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  parameter  int ADDR_W    = 12,
  parameter  int DATA_W    = 64,
  localparam int WE_W      = DATA_W / 8,
  localparam int BANK_W    = clog2(NUM_BANKS)
) (
  input  logic                        trn_clk,
  input  logic                        trn_reset,
  input  logic                        wr_valid,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [WE_W-1:0]             wr_be,
  input  logic                        wr_last,
  output logic                        wr_ready,
  output logic [NUM_BANKS*WE_W-1:0]   bram_we_a,
  output logic [ADDR_W-1:0]           bram_addr_a,
  output logic [DATA_W-1:0]           bram_din_a,
  output logic                        rd_avail,
  output logic [BANK_W-1:0]           rd_bank,
  output logic [ADDR_W:0]             rd_len,
  input  logic                        rd_done,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [ADDR_W-1:0]           bram_addr_b,
  input  logic [NUM_BANKS*DATA_W-1:0] bram_dout_b,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        ovf
`ifdef DDRBRAM_OVF_COUNT_EN
  ,
  output logic [OVF_CNT_W-1:0]        ovf_cnt
`endif
);

  localparam int                FC_W    = clog2(NUM_BANKS + 1);
  localparam logic [FC_W-1:0]   FC_FULL = FC_W'(NUM_BANKS);

  logic [BANK_W-1:0]         w_wp;
  logic [BANK_W-1:0]         w_rp;
  logic [FC_W-1:0]           r_fc;
  logic [ADDR_W-1:0]         r_wa;
  logic [ADDR_W:0]           r_len [NUM_BANKS];
  logic [NUM_BANKS*WE_W-1:0] r_we;
  logic [ADDR_W-1:0]         r_addr;
  logic [DATA_W-1:0]         r_din;
  logic                      r_ovf;
  bank_state_e               w_state [NUM_BANKS];
  logic                      w_accept;
  logic                      w_close;
  logic                      w_release;

  // Banks rp..rp+fc-1 (mod NUM_BANKS) are FULL; wp is FILL while room remains.
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_state[k] = FREE;
      if (((k >= int'(w_rp)) ? k - int'(w_rp) : k - int'(w_rp) + NUM_BANKS) < int'(r_fc))
        w_state[k] = FULL;
      else if (k == int'(w_wp) && r_fc != FC_FULL)
        w_state[k] = FILL;
    end
  end

  assign wr_ready  = (w_state[w_wp] == FILL);
  assign rd_avail  = (w_state[w_rp] == FULL);
  assign w_accept  = wr_valid & wr_ready;
  assign w_close   = w_accept & (wr_last | (&r_wa));
  assign w_release = rd_done & rd_avail;

  bram_bank_ptr #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_wp (
    .trn_clk   (trn_clk),
    .trn_reset (trn_reset),
    .i_inc     (w_close),
    .o_ptr     (w_wp)
  );

  bram_bank_ptr #(.NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)) u_rp (
    .trn_clk   (trn_clk),
    .trn_reset (trn_reset),
    .i_inc     (w_release),
    .o_ptr     (w_rp)
  );

  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) begin
      r_fc   <= '0;
      r_wa   <= '0;
      r_we   <= '0;
      r_addr <= '0;
      r_din  <= '0;
      r_ovf  <= 1'b0;
      // NOTE: the length table is a small flop array, not a RAM, so it can be reset.
      for (int k = 0; k < NUM_BANKS; k++) r_len[k] <= '0;
    end else begin
      r_ovf <= wr_valid & ~wr_ready;
      r_we  <= '0;
      if (w_accept) begin
        r_we[int'(w_wp)*WE_W +: WE_W] <= wr_be;
        r_addr <= r_wa;
        r_din  <= wr_data;
        r_wa   <= w_close ? '0 : r_wa + 1'b1;
      end
      if (w_close) r_len[w_wp] <= {1'b0, r_wa} + 1'b1;
      // A close and a release in the same cycle cancel out in the full count.
      case ({w_close, w_release})
        2'b10:   r_fc <= r_fc + 1'b1;
        2'b01:   r_fc <= r_fc - 1'b1;
        default: r_fc <= r_fc;
      endcase
    end
  end

  assign bram_we_a   = r_we;
  assign bram_addr_a = r_addr;
  assign bram_din_a  = r_din;
  assign ovf         = r_ovf;
  assign rd_bank     = w_rp;
  assign rd_len      = r_len[w_rp];
  assign bram_addr_b = rd_addr;
  assign rd_data     = bram_dout_b[int'(w_rp)*DATA_W +: DATA_W];

`ifdef DDRBRAM_OVF_COUNT_EN
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset)
      r_ovf_cnt <= '0;
    else if (wr_valid & ~wr_ready & ~(&r_ovf_cnt))
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_bram_bank_ring.sv
// Self-checking bench for bram_bank_ring: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the bank ring.
module tb_bram_bank_ring;

  localparam int NB  = 2;
  localparam int AW  = 12;
  localparam int DW  = 64;
  localparam int WEW = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid, wr_last, wr_ready, rd_avail, rd_done, ovf;
  logic [DW-1:0]     wr_data, bram_din_a, rd_data;
  logic [WEW-1:0]    wr_be;
  logic [NB*WEW-1:0] bram_we_a;
  logic [AW-1:0]     bram_addr_a, rd_addr, bram_addr_b;
  logic [0:0]        rd_bank;
  logic [AW:0]       rd_len;
  logic [NB*DW-1:0]  bram_dout_b;
`ifdef DDRBRAM_OVF_COUNT_EN
  logic [15:0]       ovf_cnt, ovf_cnt4;
`endif

  // Second instance: 4 banks, small depth, 16-bit data.
  logic        wr_valid4, wr_last4, wr_ready4, rd_avail4, rd_done4, ovf4;
  logic [15:0] wr_data4, bram_din_a4, rd_data4;
  logic [1:0]  wr_be4, rd_bank4;
  logic [7:0]  bram_we_a4;
  logic [2:0]  bram_addr_a4, rd_addr4, bram_addr_b4;
  logic [3:0]  rd_len4;
  logic [63:0] bram_dout_b4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_bank_ring #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .trn_clk(clk), .trn_reset(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_be(wr_be), .wr_last(wr_last),
    .wr_ready(wr_ready), .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a),
    .bram_din_a(bram_din_a), .rd_avail(rd_avail), .rd_bank(rd_bank), .rd_len(rd_len),
    .rd_done(rd_done), .rd_addr(rd_addr), .bram_addr_b(bram_addr_b),
    .bram_dout_b(bram_dout_b), .rd_data(rd_data), .ovf(ovf)
`ifdef DDRBRAM_OVF_COUNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  bram_bank_ring #(.NUM_BANKS(4), .ADDR_W(3), .DATA_W(16)) u_dut4 (
    .trn_clk(clk), .trn_reset(rst),
    .wr_valid(wr_valid4), .wr_data(wr_data4), .wr_be(wr_be4), .wr_last(wr_last4),
    .wr_ready(wr_ready4), .bram_we_a(bram_we_a4), .bram_addr_a(bram_addr_a4),
    .bram_din_a(bram_din_a4), .rd_avail(rd_avail4), .rd_bank(rd_bank4), .rd_len(rd_len4),
    .rd_done(rd_done4), .rd_addr(rd_addr4), .bram_addr_b(bram_addr_b4),
    .bram_dout_b(bram_dout_b4), .rd_data(rd_data4), .ovf(ovf4)
`ifdef DDRBRAM_OVF_COUNT_EN
    , .ovf_cnt(ovf_cnt4)
`endif
  );

  // Reference model: a FIFO of closed-bank lengths plus the bank being filled.
  int                m_wp, m_rp, m_wa, m_ovf_cnt;
  int                m_q[$];
  int                m_len[NB];
  logic [NB*WEW-1:0] m_we;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_din;
  logic              m_ovf;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_wa = 0; m_ovf_cnt = 0;
    m_q.delete();
    for (int k = 0; k < NB; k++) m_len[k] = 0;
    m_we = '0; m_addr = '0; m_din = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit ready, accept, close;
    ready  = (m_q.size() < NB);
    accept = wr_valid && ready;
    close  = accept && (wr_last || m_wa == (1 << AW) - 1);
    m_ovf  = wr_valid && !ready;
    if (m_ovf && m_ovf_cnt < 65535) m_ovf_cnt++;
    m_we = '0;
    if (rd_done && m_q.size() > 0) begin
      void'(m_q.pop_front());
      m_rp = (m_rp + 1) % NB;
    end
    if (accept) begin
      m_we[m_wp*WEW +: WEW] = wr_be;
      m_addr = AW'(m_wa);
      m_din  = wr_data;
      if (close) begin
        m_len[m_wp] = m_wa + 1;
        m_q.push_back(m_wa + 1);
        m_wp = (m_wp + 1) % NB;
        m_wa = 0;
      end else begin
        m_wa++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("wr_ready", wr_ready, m_q.size() < NB);
      check("rd_avail", rd_avail, m_q.size() > 0);
      check("rd_bank", rd_bank, m_rp);
      check("rd_len", rd_len, (m_q.size() > 0) ? m_q[0] : m_len[m_rp]);
      check("rd_data", rd_data, bram_dout_b[m_rp*DW +: DW]);
      check("bram_addr_b", bram_addr_b, rd_addr);
      check("bram_we_a", bram_we_a, m_we);
      check("bram_addr_a", bram_addr_a, m_addr);
      check("bram_din_a", bram_din_a, m_din);
      check("ovf", ovf, m_ovf);
`ifdef DDRBRAM_OVF_COUNT_EN
      check("ovf_cnt", ovf_cnt, m_ovf_cnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic put_word(input bit last, input bit done, input logic [WEW-1:0] be);
    wr_valid = 1'b1;
    wr_data  = {$urandom, $urandom};
    wr_be    = be;
    wr_last  = last;
    rd_done  = done;
    cyc();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd_done  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    wr_valid = 1'b0; wr_last = 1'b0; rd_done = 1'b0;
    #1;
    check("rst_we", bram_we_a, '0);
    check("rst_addr_a", bram_addr_a, '0);
    check("rst_din_a", bram_din_a, '0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_avail", rd_avail, 0);
    check("rst_rd_len", rd_len, 0);
    check("rst_ovf", ovf, 0);
`ifdef DDRBRAM_OVF_COUNT_EN
    check("rst_ovf_cnt", ovf_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    wr_valid = 0; wr_last = 0; wr_data = '0; wr_be = '0; rd_done = 0; rd_addr = '0;
    bram_dout_b = {$urandom, $urandom, $urandom, $urandom};
    wr_valid4 = 0; wr_last4 = 0; wr_data4 = '0; wr_be4 = '0; rd_done4 = 0; rd_addr4 = '0;
    bram_dout_b4 = '0;
    model_reset();
    #2;
    do_reset();

    // Early wr_last: 11-word bank, then the next word lands in bank 1 at address 0.
    for (int i = 0; i < 11; i++) put_word(i == 10, 0, WEW'($urandom));
    check("len11_rd_len", rd_len, 11);
    check("len11_rd_bank", rd_bank, 0);
    check("len11_rd_avail", rd_avail, 1);
    put_word(0, 0, 8'hFF);
    check("len11_next_we", bram_we_a, 16'hFF00);
    check("len11_next_addr", bram_addr_a, 0);

    // Bank 1 closes in the same cycle bank 0 is released.
    for (int i = 0; i < 4; i++) put_word(0, 0, WEW'($urandom));
    put_word(1, 1, WEW'($urandom));
    check("simul_rd_avail", rd_avail, 1);
    check("simul_rd_bank", rd_bank, 1);
    check("simul_rd_len", rd_len, 6);
    check("simul_wr_ready", wr_ready, 1);
    put_word(0, 0, 8'hFF);
    check("simul_wrap_we", bram_we_a, 16'h00FF);
    check("simul_wrap_addr", bram_addr_a, 0);

    // Full-depth bank closes on address wrap.
    do_reset();
    for (int i = 0; i < 4096; i++) put_word(0, 0, WEW'($urandom));
    check("depth_rd_avail", rd_avail, 1);
    check("depth_rd_bank", rd_bank, 0);
    check("depth_rd_len", rd_len, 4096);
    put_word(0, 0, 8'hFF);
    check("depth_next_we", bram_we_a, 16'hFF00);
    check("depth_next_addr", bram_addr_a, 0);

    // Both banks full: three dropped words.
    for (int i = 0; i < 3; i++) put_word(i == 2, 0, WEW'($urandom));
    check("full_wr_ready", wr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      put_word(0, 0, 8'hFF);
      check("drop_ovf", ovf, 1);
      check("drop_we", bram_we_a, '0);
    end
`ifdef DDRBRAM_OVF_COUNT_EN
    check("drop_ovf_cnt", ovf_cnt, 3);
`endif
    cyc();
    check("drop_ovf_clear", ovf, 0);

    // Asynchronous reset mid-fill at wa=100.
    do_reset();
    for (int i = 0; i < 100; i++) put_word(0, 0, 8'hFF);
    check("midfill_addr", bram_addr_a, 99);
    #2;
    do_reset();
    put_word(0, 0, 8'hFF);
    check("postrst_we", bram_we_a, 16'h00FF);
    check("postrst_addr", bram_addr_a, 0);

    // Random traffic: slow reader first (overflows), then fast reader.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      wr_valid    = ($urandom_range(0, 9) < 7);
      wr_last     = ($urandom_range(0, 19) == 0);
      rd_done     = (i < 1500) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 6) == 0);
      wr_data     = {$urandom, $urandom};
      wr_be       = WEW'($urandom);
      rd_addr     = AW'($urandom);
      bram_dout_b = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    wr_valid = 0; wr_last = 0; rd_done = 0;

    // Four-bank instance: read mux selects bank 2.
    do_reset();
    wr_valid4 = 1; wr_last4 = 1; wr_be4 = 2'b11; wr_data4 = 16'h1234;
    repeat (3) cyc();
    wr_valid4 = 0; wr_last4 = 0;
    check("nb4_we_bank2", bram_we_a4, 8'h30);
    rd_done4 = 1;
    repeat (2) cyc();
    rd_done4 = 0;
    rd_addr4 = 3'd5;
    bram_dout_b4 = 64'hDDDD_CCCC_BBBB_AAAA;
    #1;
    check("nb4_rd_bank", rd_bank4, 2);
    check("nb4_rd_avail", rd_avail4, 1);
    check("nb4_rd_len", rd_len4, 1);
    check("nb4_addr_b", bram_addr_b4, 5);
    check("nb4_rd_data", rd_data4, 16'hCCCC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_bank_ring.md
BRAM_BANK_RING -- requirements
Module: bram_bank_ring

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of BRAM banks in the ring (legal range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 12, word-address width per bank; bank depth is 2^ADDR_W.
REQ-003 SHALL have parameter DATA_W, default 64, data width; byte-enable width WE_W = DATA_W/8; BANK_W = clog2(NUM_BANKS).
REQ-004 SHALL have ports, clock and reset first, as listed in REQ-005 to REQ-023.
REQ-005 trn_clk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-006 trn_reset  in  1  reset, asynchronous, active-high.
REQ-007 wr_valid  in  1  input word valid.
REQ-008 wr_data  in  DATA_W  input word.
REQ-009 wr_be  in  WE_W  input byte enables.
REQ-010 wr_last  in  1  close the current bank after this word; qualified by wr_valid.
REQ-011 wr_ready  out  1  a free or filling bank exists.
REQ-012 bram_we_a  out  NUM_BANKS*WE_W  per-bank port-A byte enables; bank k occupies slice k.
REQ-013 bram_addr_a  out  ADDR_W  shared port-A address.
REQ-014 bram_din_a  out  DATA_W  shared port-A data.
REQ-015 rd_avail  out  1  at least one full bank is waiting.
REQ-016 rd_bank  out  BANK_W  index of the oldest full bank.
REQ-017 rd_len  out  ADDR_W+1  word count of rd_bank.
REQ-018 rd_done  in  1  one-cycle pulse releasing rd_bank.
REQ-019 rd_addr  in  ADDR_W  reader word address.
REQ-020 bram_addr_b  out  ADDR_W  shared port-B address, equal to rd_addr combinationally.
REQ-021 bram_dout_b  in  NUM_BANKS*DATA_W  per-bank port-B read data.
REQ-022 rd_data  out  DATA_W  slice rd_bank of bram_dout_b, combinational mux.
REQ-023 ovf  out  1  one-cycle pulse when a valid word is dropped.

Function
REQ-024 SHALL keep a write-bank pointer wp, a read-bank pointer rp, a full-bank count fc (0..NUM_BANKS) and a word pointer wa; both bank pointers wrap from NUM_BANKS-1 to 0.
REQ-025 Each bank SHALL be in state FREE, FILL or FULL: wp bank is FILL whenever fc<NUM_BANKS; banks rp..rp+fc-1 are FULL; all others are FREE.
REQ-026 An accepted word (wr_valid & wr_ready) SHALL register into bram_we_a slice wp = wr_be, bram_addr_a = wa and bram_din_a = wr_data, one cycle of latency; all other slices are 0.
REQ-027 After an accepted word, wa SHALL increment; the bank SHALL close if wr_last=1 or wa=2^ADDR_W-1.
REQ-028 A bank close SHALL store len[wp]=wa+1, advance wp, clear wa to 0 and increment fc.
REQ-029 wr_ready SHALL be asserted exactly when fc<NUM_BANKS.
REQ-030 wr_valid with wr_ready=0 SHALL drop the word, produce no BRAM write and pulse ovf on the next cycle.
REQ-031 rd_avail SHALL be asserted exactly when fc>0; rd_len SHALL equal len[rp].
REQ-032 rd_done with rd_avail=1 SHALL advance rp and decrement fc; rd_done with rd_avail=0 SHALL be ignored.
REQ-033 A simultaneous bank close and rd_done SHALL leave fc unchanged while both pointers advance.
REQ-034 wr_last on the first word of a bank SHALL yield len=1; a bank can never close empty.

Reset
REQ-035 Assertion of trn_reset SHALL immediately clear wp, rp, fc, wa, all len entries, bram_we_a, bram_addr_a, bram_din_a, ovf and ovf_cnt to 0.
REQ-036 Reset mid-fill SHALL discard the partial bank and all full banks; wr_ready=1 and rd_avail=0 from reset release.

Configuration
REQ-037 With macro DDRBRAM_OVF_COUNT_EN defined, the block SHALL have output ovf_cnt [15:0], which increments on every dropped word and saturates at 16'hFFFF.
REQ-038 Without DDRBRAM_OVF_COUNT_EN, the ovf_cnt port and counter SHALL be absent; ovf behaviour is unchanged.

Structure
REQ-039 A shared package SHALL hold the bank-state enum (FREE/FILL/FULL), the ovf_cnt width constant (16) and the clog2 helper.
REQ-040 SHALL contain one sub-module, bram_bank_ptr, implementing the wrapping bank pointer with increment enable; it is instantiated for wp and rp.

Verification
REQ-041 Reset, then 4096 contiguous words with NUM_BANKS=2: bank 0 closes, rd_avail=1, rd_bank=0, rd_len=4096, wp=1.
REQ-042 Word with wr_last=1 at word 10 of a bank: rd_len=11; the next word writes bank 1 at address 0.
REQ-043 Fill both banks without rd_done, then 3 further valid words: wr_ready=0, 3 ovf pulses, ovf_cnt=3 (macro on), no bram_we_a activity.
REQ-044 Same cycle bank-1 close and rd_done on bank 0: fc stays 1, rd_bank=1, wp wraps to 0.
REQ-045 NUM_BANKS=4, rd_addr=5 with rd_bank=2: bram_addr_b=5 and rd_data equals bram_dout_b slice 2.
REQ-046 trn_reset asserted mid-fill at wa=100: outputs clear asynchronously; after release, the first word writes bank 0 at address 0.
